// File: rtl/bcd_score_converter.sv
// Iterative double-dabble binary-to-BCD converter with a start/done handshake.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with 4'hF at completion.
module bcd_score_converter #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  // state | meaning
  // IDLE  | waiting for start; result registers hold the last conversion
  // CONV  | one add-3/shift iteration per cycle, BIN_WIDTH cycles total
  typedef enum logic {IDLE, CONV} state_t;

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_sr_q;
  logic [BCD_W-1:0]     scratch_q, corr, scratch_d, result;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 last_shift;

  assign last_shift = (state_q == CONV) && (cnt_q == CNT_W'(BIN_WIDTH - 1));

  always_comb begin
    corr = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) corr[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    scratch_d = {corr[BCD_W-2:0], bin_sr_q[BIN_WIDTH-1]};
    // A carry out of the top digit means the value needs more than DIGITS digits.
    ovf_d     = ovf_q | corr[BCD_W-1];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  always_comb begin
    result = scratch_d;
    lead   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (scratch_d[4*i +: 4] == 4'd0)) result[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
  end
`else
  assign result = scratch_d;
`endif

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = CONV;
      CONV: begin
        busy = 1'b1;
        if (last_shift) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_sr_q  <= '0;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      done      <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_sr_q  <= bin_in;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
          end
        end
        CONV: begin
          bin_sr_q  <= bin_sr_q << 1;
          scratch_q <= scratch_d;
          ovf_q     <= ovf_d;
          cnt_q     <= cnt_q + 1'b1;
          if (last_shift) begin
            bcd_out  <= result;
            overflow <= ovf_d;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_score_converter.sv
// Directed bench for bcd_score_converter: a 5-digit and a 4-digit instance share stimulus.
// Expected values follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_bcd_score_converter;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk, rst, start;
  logic [15:0] bin_in;
  logic        busy, done, overflow;
  logic [19:0] bcd_out;
  logic        busy4, done4, overflow4;
  logic [15:0] bcd_out4;

  int checks = 0;
  int errors = 0;

  bcd_score_converter #(.BIN_WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  bcd_score_converter #(.BIN_WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy4), .done(done4), .bcd_out(bcd_out4), .overflow(overflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Turns a plain BCD expectation into its blanked form when blanking is built in.
  function automatic logic [19:0] blk(input logic [19:0] x, input int nd);
    logic [19:0] r;
    bit lead;
    r    = x;
    lead = 1'b1;
    for (int i = nd - 1; i >= 1; i--) begin
      if (BLANK && lead && (x[4*i +: 4] == 4'h0)) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < maxc) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Called 1 time unit after a posedge with the DUT idle.
  task automatic conv(input logic [15:0] v, input logic [19:0] e5, input logic e5o,
                      input logic [15:0] e4, input logic e4o, input bit chk4, input string nm);
    logic [19:0] x5, x4;
    int cyc;
    x5 = blk(e5, 5);
    x4 = blk({4'h0, e4}, 4);
    start = 1'b1; bin_in = v;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL %s accept: busy=%b done=%b, want busy=1 done=0", nm, busy, done);
    end
    wait_done(40, cyc);
    checks++;
    if (cyc !== 16) begin
      errors++; $display("FAIL %s latency: %0d cycles, want 16", nm, cyc);
    end
    checks++;
    if (bcd_out !== x5) begin
      errors++; $display("FAIL %s bcd_out: got %h, want %h", nm, bcd_out, x5);
    end
    checks++;
    if (overflow !== e5o || busy !== 1'b0) begin
      errors++; $display("FAIL %s overflow/busy: got %b/%b, want %b/0", nm, overflow, busy, e5o);
    end
    if (chk4) begin
      checks++;
      if (bcd_out4 !== x4[15:0] || done4 !== 1'b1) begin
        errors++; $display("FAIL %s bcd_out4: got %h done4=%b, want %h done4=1", nm, bcd_out4, done4, x4[15:0]);
      end
      checks++;
      if (overflow4 !== e4o) begin
        errors++; $display("FAIL %s overflow4: got %b, want %b", nm, overflow4, e4o);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL %s done_width: done=%b one cycle later, want 0", nm, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 20'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b bcd=%h ovf=%b, want 0/0/00000/0", busy, done, bcd_out, overflow);
    end
  endtask

  task automatic test_basic();
    conv(16'd1234, 20'h01234, 1'b0, 16'h1234, 1'b0, 1'b1, "bin_1234");
  endtask

  task automatic test_values();
    conv(16'd65535, 20'h65535, 1'b0, 16'h0, 1'b0, 1'b0, "bin_65535");
    conv(16'd0,     20'h00000, 1'b0, 16'h0000, 1'b0, 1'b1, "bin_0");
    conv(16'd10005, 20'h10005, 1'b0, 16'h0, 1'b0, 1'b0, "bin_10005");
  endtask

  task automatic test_digits4();
    conv(16'd9999,  20'h09999, 1'b0, 16'h9999, 1'b0, 1'b1, "d4_9999");
    conv(16'd10000, 20'h10000, 1'b0, 16'h0000, 1'b1, 1'b1, "d4_10000");
  endtask

  task automatic test_busy_ignore();
    int cyc, extra;
    logic [19:0] x;
    x = blk(20'h00042, 5);
    start = 1'b1; bin_in = 16'd42;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; bin_in = 16'd999;
    @(posedge clk); #1;
    start = 1'b0; bin_in = '0;
    wait_done(40, cyc);
    checks++;
    if (cyc !== 11 || bcd_out !== x) begin
      errors++; $display("FAIL busy_ignore result: %0d cycles bcd=%h, want 11 cycles bcd=%h", cyc, bcd_out, x);
    end
    extra = 0;
    repeat (25) begin @(posedge clk); #1; if (done === 1'b1) extra++; end
    checks++;
    if (extra !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_ignore extra_done: %0d extra pulses busy=%b, want 0 busy=0", extra, busy);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    start = 1'b1; bin_in = 16'd500;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 20'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b bcd=%h ovf=%b, want 0/0/00000/0", busy, done, bcd_out, overflow);
    end
    extra = 0;
    repeat (20) begin @(posedge clk); #1; if (done === 1'b1) extra++; end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL reset_mid no_done: %0d pulses, want 0", extra);
    end
    conv(16'd7, 20'h00007, 1'b0, 16'h0007, 1'b0, 1'b1, "after_reset_7");
  endtask

  // With start held, the done cycle is an IDLE cycle that accepts the next request.
  task automatic test_back_to_back();
    int cyc;
    logic [19:0] exp_v [3];
    exp_v[0] = blk(20'h00012, 5);
    exp_v[1] = blk(20'h00013, 5);
    exp_v[2] = blk(20'h00014, 5);
    start = 1'b1; bin_in = 16'd12;
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) begin
      bin_in = 16'd13 + 16'(n);
      if (n == 2) start = 1'b0;
      wait_done(40, cyc);
      checks++;
      if (cyc !== 16 || bcd_out !== exp_v[n]) begin
        errors++;
        $display("FAIL back_to_back_%0d: %0d cycles bcd=%h, want 16 cycles bcd=%h", n, cyc, bcd_out, exp_v[n]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL back_to_back_end: busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin_in = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_values();
    test_digits4();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
